// File: rtl/fifo_dma_drain_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_dma_drain_ctrl
//
// Drains the parser-output FIFO into a circular buffer in memory. Words are
// popped one at a time and issued as word-addressed write beats, grouped into
// bursts of up to BURST_LEN beats. A burst closes early only when flush is
// high and the FIFO runs dry; otherwise a partial burst is held open in FETCH
// until more data arrives.
//
// Handshake: a beat is transferred on a rising clk edge where o_mem_req and
// i_mem_ack are both high. o_mem_addr/o_mem_wdata/o_mem_last are held stable
// while o_mem_req is high; i_mem_ack is ignored while o_mem_req is low. The
// FIFO is popped by o_fifo_rd_en (never raised while i_fifo_empty is high);
// i_fifo_rdata is valid the cycle after the pop.
//
// Ports:
//   clk              clock
//   rst              asynchronous, active-low reset
//   i_enable         permits starting new bursts (checked only at beat 0)
//   i_flush          permits closing a partial burst when the FIFO runs dry
//   i_fifo_empty     FIFO empty flag
//   i_fifo_rdata     FIFO read data
//   o_fifo_rd_en     FIFO pop request (combinational)
//   o_mem_req        write beat valid
//   o_mem_addr       beat word address (BASE_ADDR + circular offset)
//   o_mem_wdata      beat data
//   o_mem_last       final beat of the burst
//   i_mem_ack        beat accepted by memory
//   o_busy           high whenever the FSM is not IDLE
//   o_words_written  count of acked beats (wraps at 2^16)
//   o_bursts_done    count of acked beats with o_mem_last set (wraps at 2^16)
//   o_state          current FSM state (0 IDLE, 1 FETCH, 2 WAIT_DATA, 3 SEND)
// -----------------------------------------------------------------------------
module fifo_dma_drain_ctrl #(
  parameter int WIDTH      = 32,
  parameter int BURST_LEN  = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int BASE_ADDR  = 0,
  parameter int BUF_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic                  i_fifo_empty,
  input  logic [WIDTH-1:0]      i_fifo_rdata,
  output logic                  o_fifo_rd_en,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0]      o_mem_wdata,
  output logic                  o_mem_last,
  input  logic                  i_mem_ack,
  output logic                  o_busy,
  output logic [15:0]           o_words_written,
  output logic [15:0]           o_bursts_done,
  output logic [1:0]            o_state
);

  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0]     BEAT_ONE  = BEAT_W'(1);
  // BUF_WORDS is a power of two, so the circular wrap is a simple mask.
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(BUF_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FETCH     = 2'd1,
    S_WAIT_DATA = 2'd2,
    S_SEND      = 2'd3
  } state_t;

  state_t                r_state;
  logic [BEAT_W-1:0]     r_beat;
  logic [ADDR_WIDTH-1:0] r_offset;
  logic                  r_mem_req;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0]      r_mem_wdata;
  logic                  r_mem_last;
  logic                  r_busy;
  logic [15:0]           r_words;
  logic [15:0]           r_bursts;

  logic w_start_ok;
  logic w_fifo_rd_en;
  logic w_ack;

  // A new burst needs enable; a burst already under way (beat != 0) keeps
  // popping regardless of enable.
  assign w_start_ok   = i_enable & ~i_fifo_empty;
  assign w_fifo_rd_en = (r_state == S_FETCH) & ~i_fifo_empty &
                        ((r_beat != '0) | i_enable);
  assign w_ack        = r_mem_req & i_mem_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_offset    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_words     <= '0;
      r_bursts    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
          end
        end

        S_FETCH: begin
          if (w_fifo_rd_en) begin
            r_state <= S_WAIT_DATA;
          end else if (r_beat == '0) begin
            // Nothing committed yet: give up and return to IDLE.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          // beat != 0 with an empty FIFO: hold the burst open here.
        end

        S_WAIT_DATA: begin
          r_mem_wdata <= i_fifo_rdata;
          r_mem_addr  <= BASE + r_offset;
          // i_fifo_empty here already reflects the pop just made, so
          // "flush & empty" means this word is the last one available.
          r_mem_last  <= (r_beat == LAST_BEAT) | (i_flush & i_fifo_empty);
          r_mem_req   <= 1'b1;
          r_state     <= S_SEND;
        end

        S_SEND: begin
          if (w_ack) begin
            r_mem_req <= 1'b0;
            r_offset  <= (r_offset + OFF_ONE) & OFF_MASK;
            r_words   <= r_words + 16'd1;
            if (r_mem_last) begin
              r_beat   <= '0;
              r_bursts <= r_bursts + 16'd1;
              if (w_start_ok) begin
                r_state <= S_FETCH;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_beat  <= r_beat + BEAT_ONE;
              r_state <= S_FETCH;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_fifo_rd_en    = w_fifo_rd_en;
  assign o_mem_req       = r_mem_req;
  assign o_mem_addr      = r_mem_addr;
  assign o_mem_wdata     = r_mem_wdata;
  assign o_mem_last      = r_mem_last;
  assign o_busy          = r_busy;
  assign o_words_written = r_words;
  assign o_bursts_done   = r_bursts;
  assign o_state         = r_state;

endmodule

// File: doc/fifo_dma_drain_ctrl.md
Name: fifo_dma_drain_ctrl

Overview:
Sequences the parser-output FIFO toward the DMA memory port. Pops words from the FIFO one at a time and issues them as word-addressed write bursts of up to BURST_LEN beats into a circular buffer region of memory. Owns the FIFO read port and the memory write handshake, and keeps word and burst counters for software.

Parameters:
WIDTH, 32, data word width; matches the FIFO word width.
BURST_LEN, 4, maximum beats per burst; power of 2, at least 2.
ADDR_WIDTH, 16, memory word-address width.
BASE_ADDR, 0, first word address of the circular buffer.
BUF_WORDS, 256, circular buffer size in words; power of 2, at most 2^ADDR_WIDTH.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
enable  in  1  permits starting new bursts
flush  in  1  permits closing a partial burst when the FIFO runs dry
fifo_empty  in  1  FIFO empty flag
fifo_rdata  in  WIDTH  FIFO read data; valid the cycle after an accepted fifo_rd_en
fifo_rd_en  out  1  FIFO pop request
mem_req  out  1  write beat valid
mem_addr  out  ADDR_WIDTH  beat word address
mem_wdata  out  WIDTH  beat data
mem_last  out  1  final beat of the burst
mem_ack  in  1  beat accepted by memory
busy  out  1  high whenever state is not IDLE
words_written  out  16  count of acked beats; wraps at 2^16
bursts_done  out  16  count of acked beats that had mem_last set; wraps at 2^16

Behaviour:
- Reset (async assert) sets state to IDLE. All registered outputs and counters go to 0. Write offset = 0 and beat count = 0. mem_req drops immediately, even mid-beat, and no completion is recorded.
- States: IDLE, FETCH, WAIT_DATA, SEND.
- IDLE -> FETCH when enable=1 and fifo_empty=0.
- FETCH: fifo_rd_en = (state==FETCH) & !fifo_empty & (beat!=0 | enable). This is the only combinational output.
  - If fifo_rd_en=1 -> WAIT_DATA.
  - If beat==0 and (enable=0 or fifo_empty=1) -> IDLE.
  - If beat!=0 and fifo_empty=1 -> stay in FETCH. The burst is held open.
- WAIT_DATA (1 cycle): register fifo_rdata into mem_wdata. Register mem_addr = BASE_ADDR + offset. Register mem_last = (beat==BURST_LEN-1) | (flush & fifo_empty), sampled this cycle. -> SEND.
- SEND: mem_req=1. mem_addr, mem_wdata and mem_last stay stable until mem_ack.
  - On mem_ack: mem_req drops next cycle. offset = (offset+1) mod BUF_WORDS. words_written increments.
  - If mem_last was set: beat=0, bursts_done increments, -> FETCH if enable & !fifo_empty, else IDLE.
  - Otherwise beat increments and -> FETCH.
- mem_ack is ignored while mem_req=0.
- Latency: for a pop accepted in cycle N, mem_req rises in cycle N+2. With mem_ack in the same cycle, the next pop can occur at N+3, giving a throughput of 1 word per 3 cycles.
- enable is checked only at a burst start (beat==0). Deasserting it mid-burst does not abort the burst; the burst completes.
- flush=1 with a non-empty FIFO has no effect, so bursts run to full length.
- Address wrap: offset BUF_WORDS-1 is followed by 0. A burst may straddle the wrap; the address sequence wraps mid-burst.
- fifo_rd_en is never asserted while fifo_empty=1. At most one pop is outstanding at a time.

Test Plan:
1. Reset, enable=1, push 4 words 0xA0..0xA3 -> one burst at addresses 0,1,2,3 with data 0xA0..0xA3 and mem_last only on beat 3; words_written=4, bursts_done=1; busy returns to 0.
2. Push 2 words, flush=0 -> 2 beats (addresses 0,1) then wait in FETCH with busy=1. Push 2 more -> beats at addresses 2,3, last on addr 3. Repeat with flush=1 and 2 words -> burst ends at beat 1 with mem_last=1, bursts_done=1.
3. BUF_WORDS=8, stream 12 words, mem_ack always 1 -> addresses 0..7 then 0..3. Check 3-cycle spacing between pops.
4. Hold mem_ack=0 for 5 cycles on beat 1 -> mem_req, mem_addr and mem_wdata stable all 5 cycles, no fifo_rd_en. Ack -> progress resumes.
5. Deassert enable during beat 2 of 4 -> beats 2,3 complete and no new burst starts although the FIFO is non-empty. Reassert enable -> next burst starts at address 4.
6. Assert rst during SEND of beat 1 -> mem_req=0 asynchronously and counters=0. After release, the next burst starts at BASE_ADDR.
